// File: rtl/lsb_offset_serializer.sv
// Purpose : forms x = a & b over a [MSB:LSB] operand pair with a non-zero LSB and
//           emits x one bit per PCLK cycle, lowest declared index first, each bit
//           tagged with its declared index and a running count of ones emitted.
// Latency : first bit is valid 1 cycle after the accept edge. A word takes
//           W SHIFT cycles, followed by one DONE cycle that pulses done.
// Backpressure: in_ready is high only in IDLE. While busy, in_valid is ignored and
//           a/b are not sampled. A held in_valid gives one accept every W+2 cycles.
//
// Ports:
//   PCLK                clock, all state updates on posedge
//   reset               synchronous, active-high; overrides everything
//   in_valid / in_ready operand-pair handshake (accept = in_valid & in_ready)
//   a, b  [MSB:LSB]     operands
//   ser_valid           ser_bit / ser_idx are meaningful this cycle
//   ser_bit             x[ser_idx]
//   ser_idx  [IW-1:0]   declared index of ser_bit, LSB..MSB
//   ones     [IW-1:0]   running count of ones for the current word; holds after DONE
//   done                one-cycle pulse after the last bit of a word
module lsb_offset_serializer #(
    parameter int MSB = 7,
    parameter int LSB = 1,
    parameter int IW  = 4
) (
    input  logic             PCLK,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MSB:LSB]   a,
    input  logic [MSB:LSB]   b,
    output logic             ser_valid,
    output logic             ser_bit,
    output logic [IW-1:0]    ser_idx,
    output logic [IW-1:0]    ones,
    output logic             done
);

    // Word width. IW must hold both MSB (for ser_idx) and W (for ones).
    localparam int W = MSB - LSB + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [MSB:LSB]  xr;
    logic            sel_bit;
    logic            last_bit;

    // The last index of a word is LSB + W - 1, which is MSB.
    assign last_bit = (ser_idx == IW'(LSB + W - 1));

    // Pick xr[ser_idx] by scanning the declared indices. This avoids a 0-based
    // re-index of a vector whose lowest bit is LSB.
    always_comb begin
        sel_bit = 1'b0;
        for (int q = LSB; q <= MSB; q++) begin
            if (ser_idx == IW'(q)) begin
                sel_bit = xr[q];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        ser_valid = 1'b0;
        ser_bit   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = sel_bit;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath. The word register, index and count change only on accept
    // and during SHIFT. In DONE and in IDLE without an accept, ones keeps
    // the final count of the last word.
    always_ff @(posedge PCLK) begin
        if (reset) begin
            xr      <= '0;
            ser_idx <= IW'(LSB);
            ones    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Loop over declared positions, so xr[LSB] = a[LSB] & b[LSB].
                        for (int q = LSB; q <= MSB; q++) begin
                            xr[q] <= a[q] & b[q];
                        end
                        ser_idx <= IW'(LSB);
                        ones    <= '0;
                    end
                end
                SHIFT: begin
                    ones <= ones + IW'(ser_bit);
                    if (!last_bit) begin
                        ser_idx <= ser_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsb_offset_serializer.sv
// Purpose : directed, table-driven check of lsb_offset_serializer at default
//           parameters plus an MSB=10/LSB=3 instance.
// Latency : inputs are driven and outputs are sampled on the falling edge.
// Backpressure: in_ready is sampled before each accept, and the back-to-back
//           accept spacing is measured.
module tb_lsb_offset_serializer;

    logic        PCLK = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:1]  a = '0;
    logic [7:1]  b = '0;
    logic        in_ready, ser_valid, ser_bit, done;
    logic [3:0]  ser_idx, ones;

    logic        in_valid2 = 1'b0;
    logic [10:3] a2 = '0;
    logic [10:3] b2 = '0;
    logic        in_ready2, ser_valid2, ser_bit2, done2;
    logic [3:0]  ser_idx2, ones2;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    lsb_offset_serializer #(.MSB(7), .LSB(1), .IW(4)) dut (
        .PCLK(PCLK), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ser_valid(ser_valid), .ser_bit(ser_bit),
        .ser_idx(ser_idx), .ones(ones), .done(done)
    );

    lsb_offset_serializer #(.MSB(10), .LSB(3), .IW(4)) dut2 (
        .PCLK(PCLK), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .ser_valid(ser_valid2), .ser_bit(ser_bit2),
        .ser_idx(ser_idx2), .ones(ones2), .done(done2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bit i of 'bits' is the expected value at declared index LSB+i (= i+1).
    typedef struct {
        logic [7:1] a;
        logic [7:1] b;
        logic [6:0] bits;
        int         ones;
    } vec_t;

    vec_t vt[6];

    // Entered on a falling edge with the DUT in IDLE; leaves it on a falling edge in IDLE.
    task automatic run_word(input logic [7:1] va, input logic [7:1] vb,
                            input logic [6:0] eb, input int eo, input string tag);
        chk($sformatf("%s in_ready idle", tag), in_ready, 1);
        a = va; b = vb; in_valid = 1'b1;
        @(negedge PCLK);
        in_valid = 1'b0; a = 7'h2A; b = 7'h55;
        chk($sformatf("%s in_ready busy", tag), in_ready, 0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("%s ser_valid[%0d]", tag, i), ser_valid, 1);
            chk($sformatf("%s ser_idx[%0d]", tag, i), ser_idx, i + 1);
            chk($sformatf("%s ser_bit[%0d]", tag, i), ser_bit, eb[i]);
            @(negedge PCLK);
        end
        chk($sformatf("%s done", tag), done, 1);
        chk($sformatf("%s ser_valid done", tag), ser_valid, 0);
        chk($sformatf("%s ones", tag), ones, eo);
        @(negedge PCLK);
        chk($sformatf("%s done low", tag), done, 0);
        chk($sformatf("%s ones hold", tag), ones, eo);
        chk($sformatf("%s in_ready back", tag), in_ready, 1);
    endtask

    initial begin
        int     c0;
        int     k;
        logic   seen_done;
        logic [7:0] e6;

        vt[0] = '{7'b0111111, 7'b0000010, 7'b0000010, 1};
        vt[1] = '{7'h7F, 7'h7F, 7'h7F, 7};
        vt[2] = '{7'h55, 7'h7F, 7'h55, 4};
        vt[3] = '{7'h00, 7'h7F, 7'h00, 0};
        vt[4] = '{7'h2A, 7'h6B, 7'h2A, 3};
        vt[5] = '{7'h7F, 7'h40, 7'h40, 1};

        // Reset for two cycles
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst in_ready", in_ready, 1);
        chk("rst ser_valid", ser_valid, 0);
        chk("rst ser_bit", ser_bit, 0);
        chk("rst done", done, 0);
        chk("rst ser_idx", ser_idx, 1);
        chk("rst ones", ones, 0);
        chk("rst ser_idx2", ser_idx2, 3);
        reset = 1'b0;
        @(negedge PCLK);

        for (int v = 0; v < 6; v++) begin
            run_word(vt[v].a, vt[v].b, vt[v].bits, vt[v].ones, $sformatf("vec%0d", v));
        end

        // Back-to-back with in_valid held and operands changed mid-word
        a = 7'h7F; b = 7'h7F; in_valid = 1'b1;
        c0 = cyc;
        @(negedge PCLK);
        a = 7'h00; b = 7'h00;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("b2b bit[%0d]", i), ser_bit, 1);
            chk($sformatf("b2b idx[%0d]", i), ser_idx, i + 1);
            @(negedge PCLK);
        end
        chk("b2b done", done, 1);
        chk("b2b ones", ones, 7);
        @(negedge PCLK);
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge PCLK);
            k++;
        end
        chk("b2b in_ready", in_ready, 1);
        chk("b2b accept spacing", cyc - c0, 9);
        @(negedge PCLK);
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("b2b w2 bit[%0d]", i), ser_bit, 0);
            @(negedge PCLK);
        end
        chk("b2b w2 done", done, 1);
        chk("b2b w2 ones", ones, 0);
        @(negedge PCLK);

        // Reset on the third SHIFT cycle aborts the word
        a = 7'h7F; b = 7'h7F; in_valid = 1'b1;
        @(negedge PCLK);
        in_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        chk("abort idx before", ser_idx, 3);
        reset = 1'b1;
        @(negedge PCLK);
        reset = 1'b0;
        chk("abort ser_valid", ser_valid, 0);
        chk("abort ones", ones, 0);
        chk("abort done", done, 0);
        chk("abort ser_idx", ser_idx, 1);
        chk("abort in_ready", in_ready, 1);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            if (done) seen_done = 1'b1;
        end
        chk("abort no done", seen_done, 0);
        run_word(7'h55, 7'h7F, 7'h55, 4, "post_abort");

        // MSB=10, LSB=3 instance
        e6 = 8'b1000_0001;
        a2 = 8'b1000_0001; b2 = 8'b1000_0001; in_valid2 = 1'b1;
        @(negedge PCLK);
        in_valid2 = 1'b0; a2 = '0; b2 = '0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("w8 ser_valid[%0d]", i), ser_valid2, 1);
            chk($sformatf("w8 ser_idx[%0d]", i), ser_idx2, i + 3);
            chk($sformatf("w8 ser_bit[%0d]", i), ser_bit2, e6[i]);
            @(negedge PCLK);
        end
        chk("w8 done", done2, 1);
        chk("w8 ones", ones2, 2);
        @(negedge PCLK);
        chk("w8 done low", done2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
